dbuf_frame_buffer: RTL and testbench

//  Parametrised single-clock double-buffered frame buffer, between the GPU/CPU draw path and the HDMI scan-out.

---
 rtl/hdmi_const_pkg.sv | 17 +
 rtl/fb_sdp_ram.sv | 24 ++
 rtl/dbuf_frame_buffer.sv | 180 ++++++++++++++++++
 tb/tb_dbuf_frame_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_const_pkg.sv
// rtl/hdmi_const_pkg.sv - shared HDMI/frame-buffer constants, state type and pixel helpers
package hdmi_const;

    localparam int FB_WIDTH_DEF  = 320;
    localparam int FB_HEIGHT_DEF = 180;

    typedef enum logic {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_t;

    // Low bits of each channel are zero-filled rather than replicated.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
        return {px[15:11], 3'b000, px[10:5], 2'b00, px[4:0], 3'b000};
    endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// rtl/fb_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module fb_sdp_ram #(
    parameter int DEPTH  = 57600,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dbuf_frame_buffer.sv
// rtl/dbuf_frame_buffer.sv - double-buffered RGB565 frame buffer with tear-free swap and hardware clear
module dbuf_frame_buffer
    import hdmi_const::*;
#(
    parameter int FB_WIDTH    = FB_WIDTH_DEF,
    parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter int SCALE_SHIFT = 2,
    parameter int HCOUNT_W    = 11,
    parameter int VCOUNT_W    = 10,
    parameter int DEPTH       = FB_WIDTH * FB_HEIGHT,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                wr_valid_in,
    output logic                wr_ready_out,
    input  logic [ADDR_W-1:0]   wr_addr_in,
    input  logic [15:0]         wr_data_in,
    output logic                wr_oob_out,
    input  logic                clear_in,
    input  logic [15:0]         clear_color_in,
    output logic                busy_out,
    input  logic                swap_req_in,
    output logic                swap_pending_out,
    output logic                swap_done_out,
    output logic                front_sel_out,
    input  logic                frame_start_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    output logic [7:0]          red_out,
    output logic [7:0]          green_out,
    output logic [7:0]          blue_out
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0]      DEPTH_W   = AW1'(DEPTH);
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [AW1-1:0]      WIDTH_W   = AW1'(FB_WIDTH);
    localparam logic [HCOUNT_W:0]   H_ACT     = (HCOUNT_W + 1)'(FB_WIDTH << SCALE_SHIFT);
    localparam logic [VCOUNT_W:0]   V_ACT     = (VCOUNT_W + 1)'(FB_HEIGHT << SCALE_SHIFT);

    fb_state_t         state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [15:0]       clr_color;
    logic              front_sel;
    logic              pending;
    logic              swap_done;
    logic              wr_oob;

    logic              wr_fire;
    logic              wr_in_range;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;

    assign wr_ready_out = (state == FB_IDLE) && !pending;
    assign wr_fire      = wr_valid_in && wr_ready_out;
    assign wr_in_range  = {1'b0, wr_addr_in} < DEPTH_W;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= FB_IDLE;
            clr_ptr   <= '0;
            clr_color <= '0;
            front_sel <= 1'b0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
            wr_oob    <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            wr_oob    <= wr_fire && !wr_in_range;

            case (state)
                FB_IDLE: begin
                    if (clear_in && !pending) begin
                        state     <= FB_CLEAR;
                        clr_color <= clear_color_in;
                        clr_ptr   <= '0;
                    end
                end
                FB_CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= FB_IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: state <= FB_IDLE;
            endcase

            // A request arriving with the frame boundary only arms the swap for the next boundary.
            if (frame_start_in && pending && (state == FB_IDLE)) begin
                front_sel <= !front_sel;
                pending   <= 1'b0;
                swap_done <= 1'b1;
            end else if (swap_req_in) begin
                pending <= 1'b1;
            end
        end
    end

    assign busy_out         = (state == FB_CLEAR);
    assign swap_pending_out = pending;
    assign swap_done_out    = swap_done;
    assign front_sel_out    = front_sel;
    assign wr_oob_out       = wr_oob;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr_in;
        ram_wdata = wr_data_in;
        if (state == FB_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr;
            ram_wdata = clr_color;
        end else if (wr_fire && wr_in_range) begin
            ram_we = 1'b1;
        end
    end

    logic [AW1-1:0]    rd_addr_full;
    logic              rd_active;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_active;
    logic              s1_sel;
    logic              s2_active;
    logic              s2_sel;
    logic [15:0]       rd_data0;
    logic [15:0]       rd_data1;
    logic [23:0]       rgb;

    always_comb begin
        rd_addr_full = AW1'(hcount_in >> SCALE_SHIFT)
                     + WIDTH_W * AW1'(vcount_in >> SCALE_SHIFT);
        rd_active    = ({1'b0, hcount_in} < H_ACT) && ({1'b0, vcount_in} < V_ACT)
                     && (rd_addr_full < DEPTH_W);
    end

    // The buffer select travels with the pixel so a swap cannot tear an in-flight read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_addr   <= '0;
            s1_active <= 1'b0;
            s1_sel    <= 1'b0;
            s2_active <= 1'b0;
            s2_sel    <= 1'b0;
        end else begin
            s1_addr   <= rd_active ? rd_addr_full[ADDR_W-1:0] : '0;
            s1_active <= rd_active;
            s1_sel    <= front_sel;
            s2_active <= s1_active;
            s2_sel    <= s1_sel;
        end
    end

    fb_sdp_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(16)) u_buf0 (
        .clk   (clk_in),
        .we    (ram_we && front_sel),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (s1_addr),
        .rdata (rd_data0)
    );

    fb_sdp_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(16)) u_buf1 (
        .clk   (clk_in),
        .we    (ram_we && !front_sel),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (s1_addr),
        .rdata (rd_data1)
    );

    assign rgb       = s2_active ? rgb565_to_888(s2_sel ? rd_data1 : rd_data0) : 24'h0;
    assign red_out   = rgb[23:16];
    assign green_out = rgb[15:8];
    assign blue_out  = rgb[7:0];

endmodule

// File: tb/tb_dbuf_frame_buffer.sv
// tb/tb_dbuf_frame_buffer.sv - directed self-checking bench for dbuf_frame_buffer
module tb_dbuf_frame_buffer;

    localparam int DEPTH = 57600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_oob;
    logic        clear = 1'b0;
    logic [15:0] clear_color = '0;
    logic        busy;
    logic        swap_req = 1'b0;
    logic        swap_pending;
    logic        swap_done;
    logic        front_sel;
    logic        frame_start = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [7:0]  red, green, blue;

    int n_tests = 0;
    int n_fail  = 0;

    dbuf_frame_buffer dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .wr_valid_in      (wr_valid),
        .wr_ready_out     (wr_ready),
        .wr_addr_in       (wr_addr),
        .wr_data_in       (wr_data),
        .wr_oob_out       (wr_oob),
        .clear_in         (clear),
        .clear_color_in   (clear_color),
        .busy_out         (busy),
        .swap_req_in      (swap_req),
        .swap_pending_out (swap_pending),
        .swap_done_out    (swap_done),
        .front_sel_out    (front_sel),
        .frame_start_in   (frame_start),
        .hcount_in        (hcount),
        .vcount_in        (vcount),
        .red_out          (red),
        .green_out        (green),
        .blue_out         (blue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [15:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h0, red, green, blue};
    endfunction

    initial begin
        int cnt;
        int ready_hi;
        logic fs_done;
        logic fs_front;

        // reset state
        #12;
        check("rst_front_sel", front_sel, 0);
        check("rst_pending", swap_pending, 0);
        check("rst_busy", busy, 0);
        check("rst_swap_done", swap_done, 0);
        check("rst_wr_oob", wr_oob, 0);
        check("rst_rgb", rgb_now(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_wr_ready", wr_ready, 1);

        // 1: draw two pixels into back buffer 1, swap, scan them out
        write_px(16'd0, 16'hF800);
        write_px(16'd321, 16'h07E0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("t1_pending", swap_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t1_swap_done", swap_done, 1);
        check("t1_front_sel", front_sel, 1);
        hcount = 11'd0; vcount = 10'd0;
        tick();
        hcount = 11'd4; vcount = 10'd4;
        tick();
        check("t1_rgb_red", rgb_now(), 32'h00F80000);
        check("t1_swap_done_fall", swap_done, 0);
        tick();
        check("t1_rgb_green", rgb_now(), 32'h0000FC00);

        // 2: same-cycle req+frame_start only arms; repeated requests toggle once
        swap_req = 1'b1; frame_start = 1'b1;
        tick();
        swap_req = 1'b0; frame_start = 1'b0;
        check("t2_sameedge_no_done", swap_done, 0);
        check("t2_sameedge_front", front_sel, 1);
        check("t2_pending", swap_pending, 1);
        check("t2_wr_ready_low", wr_ready, 0);
        for (int i = 0; i < 3; i++) begin
            swap_req = 1'b1;
            tick();
            swap_req = 1'b0;
            tick();
        end
        check("t2_front_held", front_sel, 1);
        pulse_frame_start();
        check("t2_done", swap_done, 1);
        check("t2_front_toggled", front_sel, 0);
        pulse_frame_start();
        check("t2_no_double_toggle", front_sel, 0);
        check("t2_wr_ready_back", wr_ready, 1);

        // 3/4: clear back buffer 1 to blue, request swap and hit a frame boundary mid-clear
        clear = 1'b1; clear_color = 16'h001F;
        tick();
        clear = 1'b0; clear_color = 16'h0;
        cnt = 0; ready_hi = 0; fs_done = 1'b0; fs_front = 1'b0;
        while (busy && cnt < 70000) begin
            if (wr_ready) ready_hi++;
            if (cnt == 10) swap_req = 1'b1;
            if (cnt == 11) swap_req = 1'b0;
            if (cnt == 100) frame_start = 1'b1;
            if (cnt == 101) begin
                frame_start = 1'b0;
                fs_done  = swap_done;
                fs_front = front_sel;
            end
            cnt++;
            tick();
        end
        check("t3_busy_cycles", cnt, DEPTH);
        check("t3_wr_ready_during_clear", ready_hi, 0);
        check("t4_no_swap_in_clear", fs_done, 0);
        check("t4_front_in_clear", fs_front, 0);
        check("t4_pending_kept", swap_pending, 1);
        pulse_frame_start();
        check("t4_done_after_clear", swap_done, 1);
        check("t4_front_after_clear", front_sel, 1);
        hcount = 11'd700; vcount = 10'd300;
        tick();
        hcount = 11'd1279; vcount = 10'd719;
        tick();
        check("t3_blue_mid", rgb_now(), 32'h000000F8);
        tick();
        check("t3_blue_corner", rgb_now(), 32'h000000F8);

        // 5: out-of-range write dropped, inactive region blanked
        write_px(16'd0, 16'hFFFF);
        write_px(16'd57599, 16'h8410);
        check("t5_ready_before_oob", wr_ready, 1);
        write_px(16'd57600, 16'h0000);
        check("t5_oob_pulse", wr_oob, 1);
        tick();
        check("t5_oob_fall", wr_oob, 0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        pulse_frame_start();
        check("t5_front", front_sel, 0);
        hcount = 11'd0; vcount = 10'd0;
        tick();
        hcount = 11'd1279; vcount = 10'd719;
        tick();
        hcount = 11'd1280; vcount = 10'd0;
        check("t5_px0_intact", rgb_now(), 32'h00F8FCF8);
        tick();
        hcount = 11'd0; vcount = 10'd720;
        check("t5_last_px_intact", rgb_now(), 32'h00808080);
        tick();
        check("t5_h_inactive", rgb_now(), 0);
        tick();
        check("t5_v_inactive", rgb_now(), 0);

        // 6: asynchronous reset in the middle of a clear
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        pulse_frame_start();
        hcount = 11'd0; vcount = 10'd0;
        clear = 1'b1; clear_color = 16'hF800;
        tick();
        clear = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("t6_busy_pre", busy, 1);
        check("t6_front_pre", front_sel, 1);
        check("t6_rgb_pre", rgb_now(), 32'h000000F8);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy_rst", busy, 0);
        check("t6_front_rst", front_sel, 0);
        check("t6_pending_rst", swap_pending, 0);
        check("t6_rgb_rst", rgb_now(), 0);
        check("t6_done_rst", swap_done, 0);
        check("t6_ready_rst", wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
